// File: rtl/tlb_defs.sv
// ============================================================================
// Module  : tlb_defs (package)
// Purpose : Shared TLB constants, INVTLB op codes and walker state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlb_defs;

   localparam int TLBNUM_DEF = 16;

   localparam logic [4:0] INV_ALL0    = 5'd0;
   localparam logic [4:0] INV_ALL1    = 5'd1;
   localparam logic [4:0] INV_G1      = 5'd2;
   localparam logic [4:0] INV_G0      = 5'd3;
   localparam logic [4:0] INV_ASID    = 5'd4;
   localparam logic [4:0] INV_ASID_VA = 5'd5;
   localparam logic [4:0] INV_GA_VA   = 5'd6;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_4M = 6'd21;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } walk_state_e;

endpackage

`default_nettype wire

// File: rtl/tlb_inv_match.sv
// ============================================================================
// Module  : tlb_inv_match
// Purpose : Combinational INVTLB/TLBSRCH rule check of one entry against operands.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_inv_match
   import tlb_defs::*;
(
   input  logic [4:0]  op,
   input  logic [9:0]  asid,
   input  logic [18:0] vppn,
   input  logic [18:0] e_vppn,
   input  logic [5:0]  e_ps,
   input  logic [9:0]  e_asid,
   input  logic        e_g,
   output logic        match
);

   logic asid_eq;
   logic vmatch;

   always_comb begin
      asid_eq = (e_asid == asid);
      // A 4MB page only compares the VPPN bits above its page offset
      if (e_ps == PS_4M) begin
         vmatch = (e_vppn[18:9] == vppn[18:9]);
      end else begin
         vmatch = (e_vppn == vppn);
      end

      match = 1'b0;
      case (op)
         INV_ALL0, INV_ALL1: match = 1'b1;
         INV_G1:             match = e_g;
         INV_G0:             match = ~e_g;
         INV_ASID:           match = ~e_g & asid_eq;
         INV_ASID_VA:        match = ~e_g & asid_eq & vmatch;
         INV_GA_VA:          match = (e_g | asid_eq) & vmatch;
         default:            match = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/tlb_inv_walker.sv
// ============================================================================
// Module  : tlb_inv_walker
// Purpose : INVTLB sequencer; walks all TLB entries and clears E on matches.
// Config  : INVTLB_CNT_EN adds the inv_cnt cleared-entry counter output.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_inv_walker
   import tlb_defs::*;
#(
   parameter  int TLBNUM = TLBNUM_DEF,
   localparam int IDXW   = $clog2(TLBNUM)
)(
   input  logic            clk,
   input  logic            resetn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [4:0]      req_op,
   input  logic [9:0]      req_asid,
   input  logic [18:0]     req_vppn,
   output logic            busy,
   output logic            done,
   output logic            op_err,
   output logic [IDXW-1:0] r_index,
   input  logic            r_e,
   input  logic [18:0]     r_vppn,
   input  logic [5:0]      r_ps,
   input  logic [9:0]      r_asid,
   input  logic            r_g,
   output logic            tlb_we,
   output logic [IDXW-1:0] tlb_w_index
`ifdef INVTLB_CNT_EN
   ,
   output logic [IDXW:0]   inv_cnt
`endif
);

   walk_state_e     state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [4:0]      op_q, op_d;
   logic [9:0]      asid_q, asid_d;
   logic [18:0]     vppn_q, vppn_d;
   logic            err_q, err_d;
   logic            req_ready_q, req_ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            op_err_q, op_err_d;
   logic            rule_match;

   tlb_inv_match u_match (
      .op     (op_q),
      .asid   (asid_q),
      .vppn   (vppn_q),
      .e_vppn (r_vppn),
      .e_ps   (r_ps),
      .e_asid (r_asid),
      .e_g    (r_g),
      .match  (rule_match)
   );

   // Read port is combinational, so the clear lands in the same cycle as the read
   assign tlb_we      = (state_q == ST_SCAN) & r_e & rule_match;
   assign r_index     = idx_q;
   assign tlb_w_index = idx_q;
   assign req_ready   = req_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign op_err      = op_err_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      op_d        = op_q;
      asid_d      = asid_q;
      vppn_d      = vppn_q;
      err_d       = err_q;
      req_ready_d = req_ready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      op_err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d        = req_op;
               asid_d      = req_asid;
               vppn_d      = req_vppn;
               idx_d       = '0;
               req_ready_d = 1'b0;
               busy_d      = 1'b1;
               if (req_op <= INV_GA_VA) begin
                  state_d = ST_SCAN;
                  err_d   = 1'b0;
               end else begin
                  state_d  = ST_DONE;
                  err_d    = 1'b1;
                  done_d   = 1'b1;
                  op_err_d = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDXW'(TLBNUM - 1)) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               op_err_d = err_q;
            end
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         op_q        <= '0;
         asid_q      <= '0;
         vppn_q      <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         op_q        <= op_d;
         asid_q      <= asid_d;
         vppn_q      <= vppn_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         op_err_q    <= op_err_d;
      end
   end

`ifdef INVTLB_CNT_EN
   logic [IDXW:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == ST_IDLE) && req_valid) begin
         cnt_d = '0;
      end else if (tlb_we) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign inv_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlb_inv_walker.sv
// ============================================================================
// Module  : tb_tlb_inv_walker
// Purpose : Randomized + directed self-checking bench for tlb_inv_walker.
// Config  : INVTLB_CNT_EN enables the inv_cnt checks.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_inv_walker;

   localparam int N = 16;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
   } ent_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [9:0]  req_asid;
   logic [18:0] req_vppn;
   logic        busy, done, op_err, tlb_we;
   logic [3:0]  r_index, tlb_w_index;
   logic        r_e, r_g;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
`ifdef INVTLB_CNT_EN
   logic [4:0]  inv_cnt;
   logic [1:0]  d2_inv_cnt;
`endif

   logic        d2_valid, d2_ready, d2_busy, d2_done, d2_err, d2_we;
   logic [0:0]  d2_rindex, d2_windex;
   logic [1:0]  e2;
   logic        ld2;

   ent_t mem    [N];
   ent_t ld_mem [N];
   logic ld;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // TLB model: bulk load, or clear E where the walker writes
   always @(posedge clk) begin
      if (ld) mem <= ld_mem;
      else if (tlb_we) mem[tlb_w_index].e <= 1'b0;
   end

   always @(posedge clk) begin
      if (ld2) e2 <= 2'b11;
      else if (d2_we) e2[d2_windex] <= 1'b0;
   end

   assign r_e    = mem[r_index].e;
   assign r_vppn = mem[r_index].vppn;
   assign r_ps   = mem[r_index].ps;
   assign r_asid = mem[r_index].asid;
   assign r_g    = mem[r_index].g;

   tlb_inv_walker #(.TLBNUM(N)) u_dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_asid(req_asid), .req_vppn(req_vppn),
      .busy(busy), .done(done), .op_err(op_err),
      .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
      .r_asid(r_asid), .r_g(r_g),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index)
`ifdef INVTLB_CNT_EN
      , .inv_cnt(inv_cnt)
`endif
   );

   tlb_inv_walker #(.TLBNUM(2)) u_dut2 (
      .clk(clk), .resetn(resetn),
      .req_valid(d2_valid), .req_ready(d2_ready), .req_op(5'd0),
      .req_asid(10'd0), .req_vppn(19'd0),
      .busy(d2_busy), .done(d2_done), .op_err(d2_err),
      .r_index(d2_rindex), .r_e(e2[d2_rindex]), .r_vppn(19'd0), .r_ps(6'd12),
      .r_asid(10'd0), .r_g(1'b0),
      .tlb_we(d2_we), .tlb_w_index(d2_windex)
`ifdef INVTLB_CNT_EN
      , .inv_cnt(d2_inv_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference rule, written directly from the INVTLB op definitions
   function automatic logic ref_hit(input logic [4:0] op, input logic [9:0] asid,
                                    input logic [18:0] va, input ent_t en);
      logic aeq, vm;
      aeq = (en.asid == asid);
      vm  = (en.ps == 6'd21) ? (en.vppn[18:9] == va[18:9]) : (en.vppn == va);
      if (!en.e) return 1'b0;
      case (op)
         5'd0, 5'd1: return 1'b1;
         5'd2:       return en.g;
         5'd3:       return !en.g;
         5'd4:       return !en.g && aeq;
         5'd5:       return !en.g && aeq && vm;
         5'd6:       return (en.g || aeq) && vm;
         default:    return 1'b0;
      endcase
   endfunction

   task automatic load_table();
      @(negedge clk) ld = 1'b1;
      @(negedge clk) ld = 1'b0;
   endtask

   task automatic run_walk(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] va);
      ent_t snap [N];
      int   exp_cnt, cyc;
      logic bad, fin;
      snap    = mem;
      bad     = (op > 5'd6);
      exp_cnt = 0;
      for (int i = 0; i < N; i++) if (ref_hit(op, asid, va, snap[i])) exp_cnt++;
      chk("idle_ready", {31'd0, req_ready}, 1);
      chk("idle_busy", {31'd0, busy}, 0);
      req_valid = 1'b1;
      req_op    = op;
      req_asid  = asid;
      req_vppn  = va;
      cyc = 0;
      fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            fin = 1'b1;
         end else if (cyc > N + 3) begin
            chk("done_timeout", 0, 1);
            fin = 1'b1;
         end else begin
            chk("scan_busy", {31'd0, busy}, 1);
            chk("scan_ready", {31'd0, req_ready}, 0);
            chk("scan_rindex", {28'd0, r_index}, 32'(cyc - 1));
            chk("scan_we", {31'd0, tlb_we}, {31'd0, ref_hit(op, asid, va, snap[(cyc - 1) % N])});
            chk("scan_windex", {28'd0, tlb_w_index}, 32'(cyc - 1));
            // Operand noise while busy must be ignored
            req_op   = 5'($urandom);
            req_asid = 10'($urandom);
            req_vppn = 19'($urandom);
         end
      end
      chk("latency", cyc, bad ? 1 : N + 1);
      chk("done_err", {31'd0, op_err}, {31'd0, bad});
      chk("done_busy", {31'd0, busy}, 1);
`ifdef INVTLB_CNT_EN
      chk("inv_cnt_done", {27'd0, inv_cnt}, exp_cnt);
`endif
      req_valid = 1'b0;
      @(negedge clk);
      chk("post_done", {31'd0, done}, 0);
      chk("post_ready", {31'd0, req_ready}, 1);
      for (int i = 0; i < N; i++)
         chk($sformatf("mem_e[%0d]", i), {31'd0, mem[i].e},
             {31'd0, snap[i].e & ~ref_hit(op, asid, va, snap[i])});
`ifdef INVTLB_CNT_EN
      chk("inv_cnt_hold", {27'd0, inv_cnt}, exp_cnt);
`endif
   endtask

   initial begin
      logic [9:0]  a;
      logic [18:0] v;
      int          cyc;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_op    = '0;
      req_asid  = '0;
      req_vppn  = '0;
      ld        = 1'b0;
      ld2       = 1'b0;
      d2_valid  = 1'b0;
      for (int i = 0; i < N; i++) ld_mem[i] = '0;
      #12;
      chk("rst_ready", {31'd0, req_ready}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_err", {31'd0, op_err}, 0);
      chk("rst_we", {31'd0, tlb_we}, 0);
      chk("rst_rindex", {28'd0, r_index}, 0);
      chk("rst_windex", {28'd0, tlb_w_index}, 0);
      @(negedge clk) resetn = 1'b1;

      // op 0, every entry valid
      for (int i = 0; i < N; i++) ld_mem[i] = {1'b1, 19'($urandom), 6'd12, 10'($urandom), 1'($urandom)};
      load_table();
      run_walk(5'd0, 10'h0, 19'h0);

      // op 4: only the non-global matching ASID entry goes
      for (int i = 0; i < N; i++) ld_mem[i] = '0;
      ld_mem[3] = {1'b1, 19'h1, 6'd12, 10'h05, 1'b0};
      ld_mem[7] = {1'b1, 19'h2, 6'd12, 10'h05, 1'b1};
      ld_mem[9] = {1'b1, 19'h3, 6'd12, 10'h06, 1'b0};
      load_table();
      run_walk(5'd4, 10'h05, 19'h0);
      chk("op4_e3", {31'd0, mem[3].e}, 0);
      chk("op4_e7", {31'd0, mem[7].e}, 1);
      chk("op4_e9", {31'd0, mem[9].e}, 1);

      // op 5: 4MB entry compares high VPPN only
      for (int i = 0; i < N; i++) ld_mem[i] = '0;
      ld_mem[2] = {1'b1, 19'h12200, 6'd21, 10'h011, 1'b0};
      ld_mem[4] = {1'b1, 19'h12344, 6'd12, 10'h011, 1'b0};
      load_table();
      run_walk(5'd5, 10'h011, 19'h12345);
      chk("op5_e2", {31'd0, mem[2].e}, 0);
      chk("op5_e4", {31'd0, mem[4].e}, 1);

      // unsupported op
      run_walk(5'd9, 10'h0, 19'h0);

      // randomized tables near the operands so every rule sees hits and misses
      for (int t = 0; t < 10; t++) begin
         a = 10'($urandom);
         v = 19'($urandom);
         for (int i = 0; i < N; i++) begin
            ld_mem[i].e    = ($urandom_range(0, 3) != 0);
            ld_mem[i].asid = $urandom_range(0, 1) ? a : (a ^ 10'h1);
            ld_mem[i].g    = 1'($urandom);
            ld_mem[i].ps   = $urandom_range(0, 1) ? 6'd21 : 6'd12;
            ld_mem[i].vppn = $urandom_range(0, 1) ? (v ^ 19'($urandom_range(0, 511)))
                                                  : (v ^ (19'($urandom_range(0, 3)) << 9));
         end
         load_table();
         run_walk((t == 9) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6)), a, v);
      end

      // reset aborts a walk at idx 5
      for (int i = 0; i < N; i++) ld_mem[i] = {1'b1, 19'($urandom), 6'd12, 10'($urandom), 1'($urandom)};
      load_table();
      req_valid = 1'b1;
      req_op    = 5'd0;
      cyc = 0;
      while (r_index != 4'd5 && cyc < N + 4) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_reach_idx5", {28'd0, r_index}, 5);
      req_valid = 1'b0;
      resetn    = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_ready", {31'd0, req_ready}, 1);
      chk("abort_we", {31'd0, tlb_we}, 0);
      chk("abort_rindex", {28'd0, r_index}, 0);
      for (int i = 0; i < N; i++)
         chk($sformatf("abort_mem_e[%0d]", i), {31'd0, mem[i].e}, (i >= 5) ? 1 : 0);
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 0);
      resetn = 1'b1;
      @(negedge clk);
      run_walk(5'd1, 10'h0, 19'h0);

      // two-entry walker
      @(negedge clk) ld2 = 1'b1;
      @(negedge clk) begin
         ld2      = 1'b0;
         d2_valid = 1'b1;
      end
      cyc = 0;
      while (!d2_done && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (!d2_done) begin
            chk("d2_we", {31'd0, d2_we}, 1);
            chk("d2_rindex", {31'd0, d2_rindex}, 32'(cyc - 1));
         end
      end
      chk("d2_latency", cyc, 3);
      chk("d2_err", {31'd0, d2_err}, 0);
`ifdef INVTLB_CNT_EN
      chk("d2_inv_cnt", {30'd0, d2_inv_cnt}, 2);
`endif
      d2_valid = 1'b0;
      @(negedge clk);
      chk("d2_mem", {30'd0, e2}, 0);
      chk("d2_ready", {31'd0, d2_ready}, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
